// File: rtl/buffer_swap_controller.sv
`default_nettype none
// ============================================================================
// Module      : buffer_swap_controller
// Description : Double-buffer swap control between a renderer (writer) and a
//               VGA scan-out (reader). The renderer fills the back buffer
//               (~readSel). When the fill is complete, swapPending is raised.
//               The display buffer is swapped on the next frameStart, so the
//               swap never happens in the middle of a frame. When no complete
//               frame is ready at frameStart, the current frame is shown again.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: BUFFER_SWAP_DROP_COUNT_EN
//   When defined, adds the dropCount output. This is a saturating count of
//   frameStart pulses that arrived with no complete back buffer.
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock, rising edge
//   resetN       in   asynchronous active-low reset
//   frameStart   in   one-cycle pulse at the first pixel of a frame
//   pixelReq     in   display requests the next pixel
//   wrValid      in   renderer presents a pixel write
//   wrReady      out  controller accepts a write (transfer = wrValid&&wrReady)
//   readEnable   out  read strobe to the double buffer
//   writeEnable  out  write strobe to the double buffer
//   rdAddr       out  display read index
//   wrAddr       out  back-buffer write index
//   readSel      out  displayed buffer (0 = A, 1 = B)
//   swapPending  out  back buffer complete, waiting for frameStart
//   swapDone     out  one-cycle pulse in the cycle after a swap
//   dropCount    out  [BUFFER_SWAP_DROP_COUNT_EN only] repeated-frame count
// ============================================================================
module buffer_swap_controller #(
  parameter int NUM_PIXELS = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              frameStart,
  input  logic              pixelReq,
  input  logic              wrValid,
  output logic              wrReady,
  output logic              readEnable,
  output logic              writeEnable,
  output logic [ADDR_W-1:0] rdAddr,
  output logic [ADDR_W-1:0] wrAddr,
  output logic              readSel,
  output logic              swapPending,
  output logic              swapDone
`ifdef BUFFER_SWAP_DROP_COUNT_EN
  ,
  output logic [15:0]       dropCount
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic {
    W_FILL = 1'b0,
    W_WAIT = 1'b1
  } wr_state_t;

  wr_state_t wr_state;
  logic      swap;

  // wrReady is a pure decode of the state register, so it is glitch-free.
  assign wrReady     = (wr_state == W_FILL);
  assign writeEnable = wrValid && wrReady;
  assign readEnable  = pixelReq;

  // The registered swapPending is used here. A last write that lands in the
  // same cycle as frameStart therefore cannot swap until the next frame.
  assign swap = frameStart && swapPending;

  // Display read counter. frameStart restarts the scan and takes priority
  // over the increment.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rdAddr <= '0;
    end else if (frameStart) begin
      rdAddr <= '0;
    end else if (pixelReq) begin
      rdAddr <= (rdAddr == LAST_ADDR) ? '0 : rdAddr + 1'b1;
    end
  end

  // Writer FSM together with the swap bookkeeping.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_state    <= W_FILL;
      wrAddr      <= '0;
      readSel     <= 1'b0;
      swapPending <= 1'b0;
      swapDone    <= 1'b0;
    end else begin
      swapDone <= swap;
      case (wr_state)
        W_FILL: begin
          if (writeEnable) begin
            if (wrAddr == LAST_ADDR) begin
              wrAddr      <= '0;
              swapPending <= 1'b1;
              wr_state    <= W_WAIT;
            end else begin
              wrAddr <= wrAddr + 1'b1;
            end
          end
        end
        W_WAIT: begin
          if (swap) begin
            readSel     <= ~readSel;
            swapPending <= 1'b0;
            wr_state    <= W_FILL;
          end
        end
        default: wr_state <= W_FILL;
      endcase
    end
  end

`ifdef BUFFER_SWAP_DROP_COUNT_EN
  // Counts frames that are repeated because no new frame was ready.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      dropCount <= 16'h0000;
    end else if (frameStart && !swapPending && (dropCount != 16'hFFFF)) begin
      dropCount <= dropCount + 16'h0001;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_buffer_swap_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_buffer_swap_controller
// Description : Self-checking bench for buffer_swap_controller. It runs
//               directed scenarios followed by a randomized phase. All
//               results are compared against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buffer_swap_controller;

  localparam int N  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          resetN;
  logic          frameStart;
  logic          pixelReq;
  logic          wrValid;
  logic          wrReady;
  logic          readEnable;
  logic          writeEnable;
  logic [AW-1:0] rdAddr;
  logic [AW-1:0] wrAddr;
  logic          readSel;
  logic          swapPending;
  logic          swapDone;
`ifdef BUFFER_SWAP_DROP_COUNT_EN
  logic [15:0]   dropCount;
`endif

  buffer_swap_controller #(
    .NUM_PIXELS (N),
    .ADDR_W     (AW)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .frameStart  (frameStart),
    .pixelReq    (pixelReq),
    .wrValid     (wrValid),
    .wrReady     (wrReady),
    .readEnable  (readEnable),
    .writeEnable (writeEnable),
    .rdAddr      (rdAddr),
    .wrAddr      (wrAddr),
    .readSel     (readSel),
    .swapPending (swapPending),
    .swapDone    (swapDone)
`ifdef BUFFER_SWAP_DROP_COUNT_EN
    ,
    .dropCount   (dropCount)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Frame-level model. The state is the number of pixels written into the
  // back buffer (0..N, where N means complete), the displayed buffer, the
  // scan position, and the repeated-frame count.
  int m_written;
  int m_rd;
  int m_drop;
  bit m_sel;
  bit m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_written = 0;
    m_rd      = 0;
    m_drop    = 0;
    m_sel     = 1'b0;
    m_done    = 1'b0;
  endtask

  task automatic check_regs(input string where);
    check({where, ".rdAddr"},      32'(rdAddr),      32'(m_rd));
    check({where, ".wrAddr"},      32'(wrAddr),      32'(m_written % N));
    check({where, ".readSel"},     32'(readSel),     32'(m_sel));
    check({where, ".swapPending"}, 32'(swapPending), 32'(m_written == N));
    check({where, ".swapDone"},    32'(swapDone),    32'(m_done));
    check({where, ".wrReady"},     32'(wrReady),     32'(m_written < N));
`ifdef BUFFER_SWAP_DROP_COUNT_EN
    check({where, ".dropCount"},   32'(dropCount),   32'(m_drop));
`endif
  endtask

  // Runs one clock cycle with the given inputs. The strobes are checked
  // before the edge. The model is advanced, then state is checked just after
  // the edge.
  task automatic step(input string where, input bit fs, input bit pr, input bit wv);
    bit accept;
    bit ready_frame;
    frameStart = fs;
    pixelReq   = pr;
    wrValid    = wv;
    #1;
    accept      = wv && (m_written < N);
    ready_frame = (m_written == N);
    check({where, ".readEnable"},  32'(readEnable),  32'(pr));
    check({where, ".writeEnable"}, 32'(writeEnable), 32'(accept));
    m_done = fs && ready_frame;
    if (fs && ready_frame) begin
      m_sel     = ~m_sel;
      m_written = 0;
    end else if (accept) begin
      m_written = m_written + 1;
    end
    if (fs && !ready_frame && m_drop < 65535) m_drop = m_drop + 1;
    if (fs)      m_rd = 0;
    else if (pr) m_rd = (m_rd + 1) % N;
    @(posedge clk);
    #1;
    check_regs(where);
  endtask

  // Reset is asserted away from the clock edge. The outputs are checked
  // before any edge, which confirms that the reset is asynchronous.
  task automatic do_reset(input string where);
    frameStart = 1'b0;
    pixelReq   = 1'b0;
    wrValid    = 1'b0;
    resetN     = 1'b0;
    #1;
    model_reset();
    check_regs({where, ".async"});
    @(posedge clk);
    #1;
    check_regs({where, ".held"});
    resetN = 1'b1;
  endtask

  initial begin
    resetN     = 1'b1;
    frameStart = 1'b0;
    pixelReq   = 1'b0;
    wrValid    = 1'b0;
    model_reset();
    #2;
    do_reset("por");

    // Fill one buffer without a frameStart. The swap then waits on frameStart.
    for (int i = 0; i < N; i++) step("fill", 1'b0, 1'b0, 1'b1);
    check("full.swapPending", 32'(swapPending), 32'd1);
    check("full.wrReady",     32'(wrReady),     32'd0);
    check("full.readSel",     32'(readSel),     32'd0);
    check("full.wrAddr",      32'(wrAddr),      32'd0);
    step("wait_write", 1'b0, 1'b0, 1'b1);   // a write is refused while waiting
    step("swap", 1'b1, 1'b0, 1'b0);
    check("swap.readSel",     32'(readSel),     32'd1);
    check("swap.swapDone",    32'(swapDone),    32'd1);
    check("swap.wrReady",     32'(wrReady),     32'd1);
    step("after_swap", 1'b0, 1'b1, 1'b0);
    check("after_swap.swapDone", 32'(swapDone), 32'd0);

    // The last write lands in the same cycle as frameStart: no swap then.
    do_reset("rst2");
    for (int i = 0; i < N - 1; i++) step("fill2", 1'b0, 1'b0, 1'b1);
    step("last_and_fs", 1'b1, 1'b0, 1'b1);
    check("last_and_fs.readSel", 32'(readSel), 32'd0);
    step("idle", 1'b0, 1'b1, 1'b0);
    step("next_fs", 1'b1, 1'b0, 1'b0);
    check("next_fs.readSel", 32'(readSel), 32'd1);

    // Read counter wrap, then frameStart forces rdAddr back to 0.
    do_reset("rst3");
    for (int i = 0; i < 20; i++) step("scan", 1'b0, 1'b1, 1'b0);
    check("scan.rdAddr", 32'(rdAddr), 32'd4);
    step("scan_fs", 1'b1, 1'b1, 1'b0);
    check("scan_fs.rdAddr", 32'(rdAddr), 32'd0);

    // Reset in the middle of a fill discards the partial frame.
    do_reset("rst4");
    for (int i = 0; i < 7; i++) step("partial", 1'b0, 1'b1, 1'b1);
    do_reset("midfill");
    for (int i = 0; i < N - 1; i++) step("refill", 1'b0, 1'b0, 1'b1);
    step("early_fs", 1'b1, 1'b0, 1'b0);
    check("early_fs.readSel", 32'(readSel), 32'd0);
    step("final_write", 1'b0, 1'b0, 1'b1);
    step("late_fs", 1'b1, 1'b0, 1'b0);
    check("late_fs.readSel", 32'(readSel), 32'd1);

    // Repeated frames with nothing rendered.
    do_reset("rst5");
    for (int i = 0; i < 3; i++) begin
      step("drop_fs", 1'b1, 1'b0, 1'b0);
      step("drop_gap", 1'b0, 1'b1, 1'b0);
    end
    check("drops.readSel", 32'(readSel), 32'd0);
`ifdef BUFFER_SWAP_DROP_COUNT_EN
    check("drops.dropCount", 32'(dropCount), 32'd3);
    // Saturation: hold frameStart high for long enough to pass 16'hFFFF.
    frameStart = 1'b1;
    pixelReq   = 1'b0;
    wrValid    = 1'b0;
    repeat (65540) @(posedge clk);
    #1;
    m_drop = 65535;
    m_rd   = 0;
    m_done = 1'b0;
    check_regs("saturate");
    frameStart = 1'b0;
`endif

    // Randomized traffic against the model.
    do_reset("rst6");
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom % 12) == 0, ($urandom % 2) == 1, ($urandom % 4) != 0);
      if (($urandom % 250) == 0) do_reset("rand_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
